// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/exec/writeback sequencer for the 16-bit CPU datapath
// Ports: CLK, RST (synchronous, active-high); run starts or restarts from IDLE/HALT;
//   imem_req/imem_addr/imem_ack/imem_rdata form the instruction fetch handshake;
//   ir/pc hold the current instruction and program counter; ph is the phase vector;
//   rf_ra1/rf_ra2/rf_wa/rf_we drive the register file; alu_q is the registered ALU result;
//   halted/err report the halt cause; instret counts retired instructions.
module cpu_seq_ctrl #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter int          FETCH_TIMEOUT = 15,
    parameter logic [3:0]  PH_F          = 4'b0001,
    parameter logic [3:0]  PH_D          = 4'b0010,
    parameter logic [3:0]  PH_E          = 4'b0100,
    parameter logic [3:0]  PH_W          = 4'b1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic [15:0] pc,
    output logic [3:0]  ph,
    output logic [3:0]  rf_ra1,
    output logic [3:0]  rf_ra2,
    output logic [3:0]  rf_wa,
    output logic        rf_we,
    input  logic [15:0] alu_q,
    output logic        halted,
    output logic [1:0]  err,
    output logic [15:0] instret
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
    // the counter holds completed wait cycles, so the last allowed one is FETCH_TIMEOUT-1
    localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);
    state_t     state, state_nx;
    logic [7:0] tcnt;
    logic [3:0] op;
    logic       legal, writes, branch, timeout;
    always_comb begin
        op       = ir[15:12];
        legal    = op <= 4'h4;
        writes   = op == 4'h1 || op == 4'h2;
        branch   = op == 4'h3 || op == 4'h4;
        timeout  = tcnt == TO_LAST;
        state_nx = state;
        case (state)
            IDLE, HALT: state_nx = run ? FETCH : state;
            FETCH:      state_nx = imem_ack ? DECODE : timeout ? HALT : FETCH;
            DECODE:     state_nx = legal ? EXEC : HALT;
            EXEC:       state_nx = WB;
            WB:         state_nx = FETCH;
            default:    state_nx = IDLE;
        endcase
        ph        = state == FETCH  ? PH_F :
                    state == DECODE ? PH_D :
                    state == EXEC   ? PH_E :
                    state == WB     ? PH_W : 4'h0;
        imem_req  = state == FETCH;
        imem_addr = pc;
        rf_we     = state == WB && writes;
        halted    = state == HALT;
        // BNZ tests its register from the rd field
        rf_ra1    = op == 4'h4 ? ir[11:8] : ir[7:4];
        rf_ra2    = ir[3:0];
        rf_wa     = ir[11:8];
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            ir      <= 16'h0000;
            err     <= 2'b00;
            instret <= 16'h0000;
            tcnt    <= 8'h00;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, HALT: if (run) begin
                    pc   <= RESET_PC;
                    err  <= 2'b00;
                    tcnt <= 8'h00;
                end
                FETCH: if (imem_ack) begin
                    ir <= imem_rdata;
                    pc <= pc + 16'd1;
                end else begin
                    tcnt <= tcnt + 8'd1;
                    if (timeout) err <= 2'b10;
                end
                DECODE: err <= (legal || op == 4'hF) ? 2'b00 : 2'b01;
                WB: begin
                    // branch target comes back from the ALU, already relative to pc+1
                    if (branch) pc <= alu_q;
                    instret <= instret + 16'd1;
                    tcnt    <= 8'h00;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: self-checking bench for cpu_seq_ctrl with memory, ALU and ISA-level model
module tb_cpu_seq_ctrl;
    localparam logic [3:0] PH_F = 4'b0001, PH_D = 4'b0010, PH_E = 4'b0100, PH_W = 4'b1000;
    logic        CLK = 1'b0, RST = 1'b1, run = 1'b0, imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0, alu_q = 16'h0;
    logic        imem_req, rf_we, halted;
    logic [15:0] imem_addr, ir, pc, instret;
    logic [3:0]  ph, rf_ra1, rf_ra2, rf_wa;
    logic [1:0]  err;

    typedef struct {logic [3:0] wa; int t;} wr_t;
    typedef struct {
        logic [15:0] instr;
        logic [3:0]  ra1, ra2, wa;
        int          nwe;
        logic [1:0]  err;
        logic [15:0] inst, pc;
    } vec_t;

    logic [15:0] mem [0:65535];
    logic [15:0] eregs [16];
    int  dly [64];
    int  fidx = 0, wcnt = 0, cyc = 0, c0 = 0, total = 0, bad = 0, nf = 0;
    bit  no_ack = 1'b0, saw_e = 1'b0;
    wr_t obs[$], ew[$];
    vec_t vt [10];

    cpu_seq_ctrl dut (
        .CLK(CLK), .RST(RST), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .ph(ph),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we),
        .alu_q(alu_q), .halted(halted), .err(err), .instret(instret)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] alu_fn(input logic [15:0] w, input logic [15:0] p);
        logic [15:0] s;
        s = {{8{w[7]}}, w[7:0]};
        case (w[15:12])
            4'h1:    return eregs[w[7:4]] + eregs[w[3:0]];
            4'h2:    return {8'h00, w[7:0]};
            4'h3:    return p + s;
            4'h4:    return eregs[w[11:8]] != 16'h0 ? p + s : p;
            default: return 16'h0;
        endcase
    endfunction

    // environment: memory responder, registered ALU and register file, write monitor
    always @(negedge CLK) begin
        if (RST) begin
            obs.delete();
            fidx = 0;
            wcnt = 0;
            alu_q = 16'h0;
            imem_ack = 1'b0;
            foreach (eregs[i]) eregs[i] = 16'h0;
        end else begin
            if (rf_we) begin
                wr_t w;
                w.wa = rf_wa;
                w.t = cyc;
                obs.push_back(w);
                eregs[rf_wa] = alu_q;
            end
            if (ph == PH_E) alu_q = alu_fn(ir, pc);
            if (imem_req && !no_ack) begin
                if (wcnt >= dly[fidx & 63]) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem[imem_addr];
                    wcnt = 0;
                    fidx++;
                end else begin
                    imem_ack = 1'b0;
                    imem_rdata = 16'($urandom);
                    wcnt++;
                end
            end else begin
                imem_ack = imem_req ? 1'b0 : 1'($urandom);
                imem_rdata = 16'($urandom);
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        c0 = cyc;
        @(negedge CLK);
        run = 1'b0;
    endtask

    task automatic wait_halt(output int rel);
        int n;
        n = 0;
        saw_e = 1'b0;
        nf = 0;
        while (!halted && n < 3000) begin
            if (ph == PH_E) saw_e = 1'b1;
            if (ph == PH_F) nf++;
            @(negedge CLK);
            n++;
        end
        rel = cyc - c0;
        chk("halt_reached", {31'h0, halted}, 32'h1);
    endtask

    // ISA-level interpreter: each instruction costs 4 cycles plus its fetch wait
    task automatic model(output int halt_t, output logic [1:0] merr,
                         output logic [15:0] minst, output logic [15:0] mpc);
        logic [15:0] r [16];
        logic [15:0] p, pn, w, s;
        int c, k;
        wr_t e;
        foreach (r[i]) r[i] = 16'h0;
        p = 16'h0; c = 1; k = 0; minst = 16'h0; halt_t = 0; merr = 2'b00; mpc = 16'h0;
        ew.delete();
        for (int n = 0; n < 100; n++) begin
            w = mem[p];
            pn = p + 16'd1;
            s = {{8{w[7]}}, w[7:0]};
            if (w[15:12] > 4'h4) begin
                halt_t = c + dly[k] + 2;
                merr = w[15:12] == 4'hF ? 2'b00 : 2'b01;
                mpc = pn;
                break;
            end
            if (w[15:12] == 4'h1 || w[15:12] == 4'h2) begin
                e.wa = w[11:8];
                e.t = c + dly[k] + 3;
                ew.push_back(e);
                r[w[11:8]] = w[15:12] == 4'h1 ? r[w[7:4]] + r[w[3:0]] : {8'h00, w[7:0]};
            end
            if (w[15:12] == 4'h3 || (w[15:12] == 4'h4 && r[w[11:8]] != 16'h0)) pn = pn + s;
            minst++;
            c += dly[k] + 4;
            k++;
            p = pn;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rel, ht;
        logic [1:0] merr;
        logic [15:0] minst, mpc;
        vt[0] = '{16'h2105, 4'h0, 4'h5, 4'h1, 1, 2'b00, 16'd1, 16'd2};
        vt[1] = '{16'h1312, 4'h1, 4'h2, 4'h3, 1, 2'b00, 16'd1, 16'd2};
        vt[2] = '{16'h0000, 4'h0, 4'h0, 4'h0, 0, 2'b00, 16'd1, 16'd2};
        vt[3] = '{16'h4A07, 4'hA, 4'h7, 4'hA, 0, 2'b00, 16'd1, 16'd2};
        vt[4] = '{16'h3001, 4'h0, 4'h1, 4'h0, 0, 2'b00, 16'd1, 16'd3};
        vt[5] = '{16'h7123, 4'h2, 4'h3, 4'h1, 0, 2'b01, 16'd0, 16'd1};
        vt[6] = '{16'hF000, 4'h0, 4'h0, 4'h0, 0, 2'b00, 16'd0, 16'd1};
        vt[7] = '{16'h5ABC, 4'hB, 4'hC, 4'hA, 0, 2'b01, 16'd0, 16'd1};
        vt[8] = '{16'hE000, 4'h0, 4'h0, 4'h0, 0, 2'b01, 16'd0, 16'd1};
        vt[9] = '{16'h2FFF, 4'hF, 4'hF, 4'hF, 1, 2'b00, 16'd1, 16'd2};
        foreach (dly[i]) dly[i] = 0;
        clear_mem();
        do_reset();
        chk("rst_ph", {28'h0, ph}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_we", {31'h0, rf_we}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_err", {30'h0, err}, 32'h0);
        chk("rst_instret", {16'h0, instret}, 32'h0);
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_ir", {16'h0, ir}, 32'h0);
        repeat (3) @(negedge CLK);
        chk("no_autostart", {27'h0, ph, imem_req}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            clear_mem();
            mem[0] = vt[i].instr;
            start();
            @(negedge CLK);
            chk($sformatf("tbl%0d_ph", i), {28'h0, ph}, {28'h0, PH_D});
            chk($sformatf("tbl%0d_ra1", i), {28'h0, rf_ra1}, {28'h0, vt[i].ra1});
            chk($sformatf("tbl%0d_ra2", i), {28'h0, rf_ra2}, {28'h0, vt[i].ra2});
            chk($sformatf("tbl%0d_wa", i), {28'h0, rf_wa}, {28'h0, vt[i].wa});
            wait_halt(rel);
            chk($sformatf("tbl%0d_err", i), {30'h0, err}, {30'h0, vt[i].err});
            chk($sformatf("tbl%0d_instret", i), {16'h0, instret}, {16'h0, vt[i].inst});
            chk($sformatf("tbl%0d_pc", i), {16'h0, pc}, {16'h0, vt[i].pc});
            chk($sformatf("tbl%0d_nwe", i), obs.size(), vt[i].nwe);
            if (vt[i].nwe == 1 && obs.size() == 1)
                chk($sformatf("tbl%0d_we_wa", i), {28'h0, obs[0].wa}, {28'h0, vt[i].wa});
        end

        do_reset();
        clear_mem();
        mem[0] = 16'h2105; mem[1] = 16'h2203; mem[2] = 16'h1312; mem[3] = 16'hF000;
        start();
        wait_halt(rel);
        chk("t1_nwr", obs.size(), 3);
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            chk($sformatf("t1_wa%0d", i), {28'h0, obs[i].wa}, i + 1);
            chk($sformatf("t1_t%0d", i), obs[i].t - c0, 4 * (i + 1));
        end
        chk("t1_halt_t", rel, 15);
        chk("t1_err", {30'h0, err}, 32'h0);
        chk("t1_instret", {16'h0, instret}, 32'd3);
        chk("t1_pc", {16'h0, pc}, 32'd4);

        mem[0] = 16'h7123;
        start();
        chk("t5_restart", {ph, imem_addr, halted, err}, {PH_F, 16'h0000, 1'b0, 2'b00});
        wait_halt(rel);
        chk("t5_halt_t", rel, 3);
        chk("t5_err", {30'h0, err}, 32'h1);
        chk("t5_instret", {16'h0, instret}, 32'd3);
        chk("t5_no_exec", {31'h0, saw_e}, 32'h0);

        do_reset();
        clear_mem();
        mem[0] = 16'h2105; mem[1] = 16'h2203; mem[2] = 16'h1312; mem[3] = 16'hF000;
        foreach (dly[i]) dly[i] = 3;
        start();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t2_wait%0d", i), {imem_req, ph, imem_addr}, {1'b1, PH_F, 16'h0000});
            @(negedge CLK);
        end
        wait_halt(rel);
        chk("t2_nwr", obs.size(), 3);
        for (int i = 0; i < obs.size() && i < 3; i++)
            chk($sformatf("t2_t%0d", i), obs[i].t - c0, 7 * (i + 1));
        chk("t2_halt_t", rel, 27);
        chk("t2_instret", {16'h0, instret}, 32'd3);
        foreach (dly[i]) dly[i] = 0;

        do_reset();
        clear_mem();
        mem[0] = 16'h30FE;
        mem[16'hFFFF] = 16'h0000;
        start();
        repeat (4) @(negedge CLK);
        chk("t3_fetch_ffff", {ph, imem_addr}, {PH_F, 16'hFFFF});
        @(negedge CLK);
        chk("t3_pc_wrap", {16'h0, pc}, 32'h0);
        chk("t3_ir_nop", {ir, ph}, {16'h0000, PH_D});
        chk("t3_no_we", obs.size(), 0);

        do_reset();
        clear_mem();
        no_ack = 1'b1;
        start();
        wait_halt(rel);
        chk("t4_fetch_cycles", nf, 15);
        chk("t4_halt_t", rel, 16);
        chk("t4_err", {30'h0, err}, 32'h2);
        chk("t4_req", {31'h0, imem_req}, 32'h0);
        no_ack = 1'b0;
        start();
        chk("t4_restart", {ph, imem_addr, halted, err}, {PH_F, 16'h0000, 1'b0, 2'b00});
        wait_halt(rel);
        chk("t4_rerun_err", {30'h0, err}, 32'h0);

        do_reset();
        clear_mem();
        mem[0] = 16'h1312;
        start();
        for (int n = 0; n < 10 && !rf_we; n++) @(negedge CLK);
        chk("t6_wb", {rf_we, ph, rf_wa}, {1'b1, PH_W, 4'h3});
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_rst_we", {31'h0, rf_we}, 32'h0);
        chk("t6_rst_state", {ph, pc, instret, halted}, {4'h0, 16'h0, 16'h0, 1'b0});
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t6_idle", {27'h0, ph, imem_req}, 32'h0);
        do_reset();
        foreach (dly[i]) dly[i] = 3;
        start();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_fetch_abort", {imem_req, ph, pc}, {1'b0, 4'h0, 16'h0});
        RST = 1'b0;
        do_reset();
        mem[0] = 16'h2105;
        start();
        @(negedge CLK);
        run = 1'b1;
        @(negedge CLK);
        chk("t6_run_ignored", {ph, imem_addr}, {PH_F, 16'h0000});
        run = 1'b0;
        wait_halt(rel);
        chk("t6_halt_t", rel, 13);
        chk("t6_nwr", obs.size(), 1);
        chk("t6_instret", {16'h0, instret}, 32'd1);
        foreach (dly[i]) dly[i] = 0;

        for (int it = 0; it < 25; it++) begin
            do_reset();
            clear_mem();
            foreach (dly[i]) dly[i] = $urandom_range(0, 3);
            for (int a = 0; a < 16; a++) begin
                case ($urandom_range(0, 9))
                    0:         mem[a] = 16'h0000;
                    1, 2, 8:   mem[a] = {4'h1, 12'($urandom)};
                    3, 4, 9:   mem[a] = {4'h2, 12'($urandom)};
                    5:         mem[a] = {4'h3, 4'($urandom), 8'($urandom_range(0, 3))};
                    6:         mem[a] = {4'h4, 4'($urandom), 8'($urandom_range(0, 3))};
                    default:   mem[a] = $urandom_range(0, 1) ? {4'($urandom_range(5, 14)), 12'($urandom)}
                                                              : 16'hF000;
                endcase
            end
            model(ht, merr, minst, mpc);
            start();
            wait_halt(rel);
            chk($sformatf("rnd%0d_nwr", it), obs.size(), ew.size());
            for (int i = 0; i < obs.size() && i < ew.size(); i++) begin
                chk($sformatf("rnd%0d_wa%0d", it, i), {28'h0, obs[i].wa}, {28'h0, ew[i].wa});
                chk($sformatf("rnd%0d_t%0d", it, i), obs[i].t - c0, ew[i].t);
            end
            chk($sformatf("rnd%0d_halt_t", it), rel, ht);
            chk($sformatf("rnd%0d_err", it), {30'h0, err}, {30'h0, merr});
            chk($sformatf("rnd%0d_instret", it), {16'h0, instret}, {16'h0, minst});
            chk($sformatf("rnd%0d_pc", it), {16'h0, pc}, {16'h0, mpc});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
